// File: rtl/cr_engine.sv
// cr_engine: credit-controlled burst source streaming RAM1 words into a downstream FIFO
module cr_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [7:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic [7:0]  ram0_addr,
  input  logic        transaction_start,
  output logic        transaction_enable,
  input  logic        fifo_rd_en,
  output logic [7:0]  credit_cnt,
  output logic [3:0]  ram1_n,
  output logic        ram1_n_vld,
  output logic [15:0] ram1_d,
  output logic        ram1_d_vld,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOOKUP, STREAM} state_t;
  logic [3:0]  ram0 [256];
  logic [15:0] ram1 [256];
  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  rd_ptr;
  logic        accept;
  assign transaction_enable = (credit_cnt >= 8'(MAX_BURST)) && !busy;
  assign accept = transaction_start && transaction_enable;
  // configuration writes; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (cfg_we && !cfg_sel) ram0[cfg_addr] <= cfg_wdata[3:0];
    if (cfg_we && cfg_sel) ram1[cfg_addr] <= cfg_wdata;
  end
  // credit counter: reserve n on the length strobe, return one per FIFO read up to full
  always_ff @(posedge clk) begin
    if (!reset_n) credit_cnt <= 8'(FIFO_DEPTH);
    else credit_cnt <= credit_cnt - (ram1_n_vld ? {4'd0, ram1_n} : 8'd0)
                     + ((fifo_rd_en && credit_cnt < 8'(FIFO_DEPTH)) ? 8'd1 : 8'd0);
  end
  // control FSM: length lookup, then stream n words from the persistent read pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_ptr     <= '0;
      ram1_n     <= '0;
      ram1_n_vld <= 1'b0;
      ram1_d     <= '0;
      ram1_d_vld <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ram1_n_vld <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          ram1_n     <= ram0[ram0_addr];
          ram1_n_vld <= 1'b1;
          busy       <= 1'b1;
          state      <= LOOKUP;
        end
        LOOKUP: if (ram1_n == 4'd0) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          ram1_d     <= ram1[rd_ptr];
          ram1_d_vld <= 1'b1;
          rd_ptr     <= rd_ptr + 8'd1;
          cnt        <= ram1_n - 4'd1;
          state      <= STREAM;
        end
        STREAM: if (cnt == 4'd0) begin
          ram1_d_vld <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end else begin
          ram1_d <= ram1[rd_ptr];
          rd_ptr <= rd_ptr + 8'd1;
          cnt    <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cr_engine.sv
// tb_cr_engine: directed scoreboard bench for cr_engine
module tb_cr_engine;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        cfg_we = 0;
  logic        cfg_sel = 0;
  logic [7:0]  cfg_addr = 0;
  logic [15:0] cfg_wdata = 0;
  logic [7:0]  ram0_addr = 0;
  logic        transaction_start = 0;
  logic        transaction_enable;
  logic        fifo_rd_en = 0;
  logic [7:0]  credit_cnt;
  logic [3:0]  ram1_n;
  logic        ram1_n_vld;
  logic [15:0] ram1_d;
  logic        ram1_d_vld;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [3:0]  m0 [256];
  logic [15:0] m1 [256];
  logic [7:0]  ptr = 0;
  logic [15:0] exp_d [$];
  logic [15:0] obs_d [$];
  logic [3:0]  exp_n [$];
  logic [3:0]  obs_n [$];

  cr_engine dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .ram0_addr(ram0_addr),
    .transaction_start(transaction_start), .transaction_enable(transaction_enable),
    .fifo_rd_en(fifo_rd_en), .credit_cnt(credit_cnt), .ram1_n(ram1_n),
    .ram1_n_vld(ram1_n_vld), .ram1_d(ram1_d), .ram1_d_vld(ram1_d_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram1_d_vld) obs_d.push_back(ram1_d);
    if (ram1_n_vld) obs_n.push_back(ram1_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cfg(input logic sel, input logic [7:0] a, input logic [15:0] d);
    cfg_we = 1; cfg_sel = sel; cfg_addr = a; cfg_wdata = d;
    if (sel) m1[a] = d; else m0[a] = d[3:0];
    tick();
    cfg_we = 0;
  endtask

  task automatic ret(input int n);
    fifo_rd_en = 1;
    repeat (n) tick();
    fifo_rd_en = 0;
  endtask

  task automatic drain();
    while (exp_d.size() > 0 && obs_d.size() > 0) chk("word", obs_d.pop_front(), exp_d.pop_front());
    while (exp_n.size() > 0 && obs_n.size() > 0) chk("len", obs_n.pop_front(), exp_n.pop_front());
    chk("words_left", obs_d.size() + exp_d.size(), 0);
    chk("lens_left", obs_n.size() + exp_n.size(), 0);
    obs_d.delete(); exp_d.delete(); obs_n.delete(); exp_n.delete();
  endtask

  task automatic launch(input logic [7:0] a);
    int k;
    k = 0;
    while (!transaction_enable && k < 200) begin tick(); k++; end
    chk("en_wait", transaction_enable, 1);
    ram0_addr = a; transaction_start = 1;
    exp_n.push_back(m0[a]);
    for (int i = 0; i < int'(m0[a]); i++) begin exp_d.push_back(m1[ptr]); ptr++; end
    tick();
    transaction_start = 0;
  endtask

  task automatic finish_burst();
    int k;
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk("busy_drop", busy, 0);
    drain();
  endtask

  initial begin
    tick(); tick();
    reset_n = 1;
    // reset state
    chk("rst_credit", credit_cnt, 16);
    chk("rst_enable", transaction_enable, 1);
    chk("rst_n", ram1_n, 0);
    chk("rst_n_vld", ram1_n_vld, 0);
    chk("rst_d", ram1_d, 0);
    chk("rst_d_vld", ram1_d_vld, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 256; i++) cfg(1, 8'(i), i < 3 ? 16'hA000 + 16'(i) : 16'h5A00 ^ 16'(i));
    cfg(0, 5, 3); cfg(0, 1, 4); cfg(0, 7, 0); cfg(0, 2, 2);
    cfg(0, 3, 3); cfg(0, 9, 15); cfg(0, 4, 5);
    // single burst with cycle-exact checks
    ram0_addr = 5; transaction_start = 1;
    exp_n.push_back(3); exp_d.push_back(16'hA000); exp_d.push_back(16'hA001); exp_d.push_back(16'hA002);
    tick(); transaction_start = 0;
    chk("sb_n_vld", ram1_n_vld, 1);
    chk("sb_n", ram1_n, 3);
    chk("sb_busy", busy, 1);
    chk("sb_en", transaction_enable, 0);
    tick();
    chk("sb_credit", credit_cnt, 13);
    chk("sb_d0_vld", ram1_d_vld, 1);
    chk("sb_d0", ram1_d, 16'hA000);
    tick(); tick();
    chk("sb_d2", ram1_d, 16'hA002);
    tick();
    chk("sb_end_vld", ram1_d_vld, 0);
    chk("sb_end_busy", busy, 0);
    chk("sb_end_en", transaction_enable, 0);
    ptr = 3;
    drain();
    ret(3);
    chk("sb_ret", credit_cnt, 16);
    // credit exhaustion
    launch(1);
    finish_burst();
    chk("ex_credit", credit_cnt, 12);
    chk("ex_en", transaction_enable, 0);
    ram0_addr = 5; transaction_start = 1;
    tick(); transaction_start = 0;
    chk("ex_ign_nvld", ram1_n_vld, 0);
    chk("ex_ign_busy", busy, 0);
    chk("ex_ign_credit", credit_cnt, 12);
    ret(3);
    chk("ex_ret_credit", credit_cnt, 15);
    chk("ex_ret_en", transaction_enable, 1);
    ret(1);
    ret(1);
    chk("sat_credit", credit_cnt, 16);
    // zero-length burst
    launch(7);
    chk("z_n_vld", ram1_n_vld, 1);
    chk("z_n", ram1_n, 0);
    tick();
    chk("z_busy", busy, 0);
    chk("z_d_vld", ram1_d_vld, 0);
    chk("z_credit", credit_cnt, 16);
    drain();
    // burst after zero length proves rd_ptr unchanged
    launch(2);
    finish_burst();
    chk("b2_credit", credit_cnt, 14);
    ret(1);
    // simultaneous reservation and return
    launch(2);
    fifo_rd_en = 1;
    chk("sim_n_vld", ram1_n_vld, 1);
    tick(); fifo_rd_en = 0;
    chk("sim_credit", credit_cnt, 14);
    finish_burst();
    // advance rd_ptr to 254 then wrap
    fifo_rd_en = 1;
    while (ptr != 8'd251) begin launch(9); finish_burst(); end
    fifo_rd_en = 0;
    ret(16);
    launch(3); finish_burst();
    ret(16);
    chk("wrap_ptr_model", ptr, 254);
    launch(3);
    finish_burst();
    ret(16);
    // reset during second word of a 5-word burst
    ram0_addr = 4; transaction_start = 1;
    exp_n.push_back(5); exp_d.push_back(m1[ptr]); exp_d.push_back(m1[8'(ptr + 1)]);
    tick(); transaction_start = 0;
    tick(); tick();
    chk("mr_d_vld_pre", ram1_d_vld, 1);
    reset_n = 0;
    tick();
    chk("mr_d_vld", ram1_d_vld, 0);
    chk("mr_credit", credit_cnt, 16);
    chk("mr_busy", busy, 0);
    reset_n = 1;
    tick();
    chk("mr_d_vld_after", ram1_d_vld, 0);
    drain();
    ptr = 0;
    launch(5);
    finish_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
